seg_capture: RTL and testbench

SEG_CAPTURE -- requirements
Module: seg_capture

---
 rtl/seg_capture.sv | 271 +++++++++++++++++++++++++++
 tb/tb_seg_capture.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_capture.sv
// -----------------------------------------------------------------------------
// seg_capture
//   Snoops the multiplexed drive of a 4-digit, active-low 7-segment display and
//   reconstructs the hex value shown on each digit. A {anodes, segments} sample
//   must stay unchanged for STABLE_CYCLES consecutive cycles before it is
//   accepted, which filters ghosting during the driver's digit transitions.
//   Once all four digits have been accepted, the frame is latched onto the
//   outputs.
//
//   Optional feature: define SEG_CAPTURE_DP_EN to capture decimal points.
//   Without it, segments[7] is ignored everywhere and dps stays 0.
//
// Parameters
//   STABLE_CYCLES  identical consecutive samples needed to accept (1..255)
//
// Ports
//   clk         in   sole clock, rising edge
//   rst         in   synchronous active-high reset
//   anodes      in   [3:0] active-low digit select, bit n = digit n
//   segments    in   [7:0] active-low segments, [6:0] = g..a, [7] = dp
//   digits      out  [15:0] latched hex values, digit n at [4n+3:4n]
//   dps         out  [3:0]  latched decimal points, active-high
//   valid       out  [3:0]  digit n held a hex code in the last frame
//   frame_done  out  one-cycle pulse when a frame is latched
//   code_err    out  one-cycle pulse: accepted pattern neither hex nor blank
//   scan_err    out  one-cycle pulse: accepted anodes with >1 bit low
// -----------------------------------------------------------------------------
module seg_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  anodes,
  input  logic [7:0]  segments,
  output logic [15:0] digits,
  output logic [3:0]  dps,
  output logic [3:0]  valid,
  output logic        frame_done,
  output logic        code_err,
  output logic        scan_err
);

  localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

`ifdef SEG_CAPTURE_DP_EN
  localparam logic [7:0] SEG_MASK = 8'hFF;
`else
  // dp bit is masked out so it never disturbs the stability compare
  localparam logic [7:0] SEG_MASK = 8'h7F;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Input stage and previous-sample register
  // ---------------------------------------------------------------------------
  logic [3:0]  anodes_q;
  logic [7:0]  segments_q;
  logic [11:0] sample;
  logic [11:0] prev_q;

  assign sample = {anodes_q, segments_q & SEG_MASK};

  // ---------------------------------------------------------------------------
  // FSM / stability counter signals
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        accept;
  logic        same;
  logic        blank_anodes;

  assign same         = (sample == prev_q);
  assign blank_anodes = (anodes_q == 4'hF);

  // ---------------------------------------------------------------------------
  // Segment decode
  // ---------------------------------------------------------------------------
  function automatic logic [4:0] decode(input logic [6:0] s);
    // returns {is_hex, value}
    case (s)
      7'h40:   return {1'b1, 4'h0};
      7'h79:   return {1'b1, 4'h1};
      7'h24:   return {1'b1, 4'h2};
      7'h30:   return {1'b1, 4'h3};
      7'h19:   return {1'b1, 4'h4};
      7'h12:   return {1'b1, 4'h5};
      7'h02:   return {1'b1, 4'h6};
      7'h78:   return {1'b1, 4'h7};
      7'h00:   return {1'b1, 4'h8};
      7'h10:   return {1'b1, 4'h9};
      7'h08:   return {1'b1, 4'hA};
      7'h03:   return {1'b1, 4'hB};
      7'h46:   return {1'b1, 4'hC};
      7'h21:   return {1'b1, 4'hD};
      7'h06:   return {1'b1, 4'hE};
      7'h0E:   return {1'b1, 4'hF};
      default: return 5'b0_0000;
    endcase
  endfunction

  logic [4:0] dec;
  logic       dec_ok;
  logic [3:0] dec_val;
  logic       is_blank;
  logic       one_hot;

  assign dec      = decode(segments_q[6:0]);
  assign dec_ok   = dec[4];
  assign dec_val  = dec[3:0];
  assign is_blank = (segments_q[6:0] == 7'h7F);
  assign one_hot  = $onehot(~anodes_q);

  // ---------------------------------------------------------------------------
  // Pending frame storage
  // ---------------------------------------------------------------------------
  logic [3:0]  pend_val_q [4];
  logic [3:0]  pend_val_d [4];
  logic [3:0]  pend_valid_q, pend_valid_d;
  logic [3:0]  pend_dp_q, pend_dp_d;
  logic [15:0] pend_flat;
  logic [3:0]  seen_q, seen_d;
  logic [3:0]  seen_next;
  logic        frame;

  logic [15:0] digits_q, digits_d;
  logic [3:0]  valid_q, valid_d;
  logic [3:0]  dps_q, dps_d;
  logic        frame_done_q, frame_done_d;
  logic        code_err_q, code_err_d;
  logic        scan_err_q, scan_err_d;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      logic hit;
      assign hit = accept && one_hot && !anodes_q[gi];
      // Hex codes store their value; blank and illegal codes store 0, not valid
      assign pend_val_d[gi]   = hit ? dec_val : pend_val_q[gi];
      assign pend_valid_d[gi] = hit ? dec_ok  : pend_valid_q[gi];
`ifdef SEG_CAPTURE_DP_EN
      assign pend_dp_d[gi]    = hit ? !segments_q[7] : pend_dp_q[gi];
`else
      assign pend_dp_d[gi]    = 1'b0;
`endif
      assign pend_flat[4*gi +: 4] = pend_val_d[gi];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Next-state: FSM and stability counter
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!blank_anodes) begin
          state_d = SETTLE;
          cnt_d   = 8'd1;
        end
      end
      SETTLE: begin
        if (blank_anodes) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (same) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          cnt_d = 8'd1;
        end
      end
      HOLD: begin
        if (blank_anodes) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (!same) begin
          state_d = SETTLE;
          cnt_d   = 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
    // Single point of acceptance: covers STABLE_CYCLES == 1, where a freshly
    // loaded counter already satisfies the threshold.
    if (state_d == SETTLE && cnt_d == STABLE_C) begin
      state_d = HOLD;
      accept  = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state: accept side effects and frame latch
  // ---------------------------------------------------------------------------
  always_comb begin
    scan_err_d   = accept && !one_hot && !blank_anodes;
    code_err_d   = accept && one_hot && !dec_ok && !is_blank;
    seen_next    = seen_q | ((accept && one_hot) ? ~anodes_q : 4'h0);
    frame        = accept && one_hot && (seen_next == 4'hF);
    frame_done_d = frame;
    seen_d       = frame ? 4'h0 : seen_next;
    digits_d     = digits_q;
    valid_d      = valid_q;
    dps_d        = dps_q;
    if (frame) begin
      // Latch includes the digit accepted this cycle
      digits_d = pend_flat;
      valid_d  = pend_valid_d;
      dps_d    = pend_dp_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      anodes_q     <= 4'hF;
      segments_q   <= 8'hFF;
      prev_q       <= {4'hF, SEG_MASK};
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      seen_q       <= 4'h0;
      pend_valid_q <= 4'h0;
      pend_dp_q    <= 4'h0;
      for (int i = 0; i < 4; i++) begin
        pend_val_q[i] <= 4'h0;
      end
      digits_q     <= 16'h0;
      valid_q      <= 4'h0;
      dps_q        <= 4'h0;
      frame_done_q <= 1'b0;
      code_err_q   <= 1'b0;
      scan_err_q   <= 1'b0;
    end else begin
      anodes_q     <= anodes;
      segments_q   <= segments;
      prev_q       <= sample;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      seen_q       <= seen_d;
      pend_valid_q <= pend_valid_d;
      pend_dp_q    <= pend_dp_d;
      for (int i = 0; i < 4; i++) begin
        pend_val_q[i] <= pend_val_d[i];
      end
      digits_q     <= digits_d;
      valid_q      <= valid_d;
      dps_q        <= dps_d;
      frame_done_q <= frame_done_d;
      code_err_q   <= code_err_d;
      scan_err_q   <= scan_err_d;
    end
  end

  assign digits     = digits_q;
  assign valid      = valid_q;
  assign dps        = dps_q;
  assign frame_done = frame_done_q;
  assign code_err   = code_err_q;
  assign scan_err   = scan_err_q;

endmodule

// File: tb/tb_seg_capture.sv
// -----------------------------------------------------------------------------
// tb_seg_capture
//   Drives holds of {anodes, segments} of chosen lengths. A hold of at least
//   STABLE cycles that differs from its neighbour counts as one accept; the
//   reference model turns accepts into expected pulse events, pushed onto a
//   queue. A monitor pops and compares whenever the DUT pulses, and checks
//   that latched outputs only move on frame_done.
// -----------------------------------------------------------------------------
module tb_seg_capture;

  localparam int STABLE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  anodes;
  logic [7:0]  segments;
  logic [15:0] digits;
  logic [3:0]  dps;
  logic [3:0]  valid;
  logic        frame_done;
  logic        code_err;
  logic        scan_err;

  seg_capture #(.STABLE_CYCLES(STABLE)) dut (
    .clk        (clk),
    .rst        (rst),
    .anodes     (anodes),
    .segments   (segments),
    .digits     (digits),
    .dps        (dps),
    .valid      (valid),
    .frame_done (frame_done),
    .code_err   (code_err),
    .scan_err   (scan_err)
  );

  always #5 clk = ~clk;

`ifdef SEG_CAPTURE_DP_EN
  localparam logic [7:0] KEY_MASK = 8'hFF;
  localparam bit         DP_ON    = 1'b1;
`else
  localparam logic [7:0] KEY_MASK = 8'h7F;
  localparam bit         DP_ON    = 1'b0;
`endif

  typedef struct {
    logic        fd;
    logic        ce;
    logic        se;
    logic [15:0] dg;
    logic [3:0]  vl;
    logic [3:0]  dp;
  } ev_t;

  ev_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // active-low 7-segment codes for hex 0..F
  logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // reference model state
  logic [3:0]  m_val [4];
  logic [3:0]  m_valid;
  logic [3:0]  m_dp;
  logic [3:0]  m_seen;

  // expected latched outputs, tracked by the monitor
  logic [15:0] cur_dg = 16'h0;
  logic [3:0]  cur_vl = 4'h0;
  logic [3:0]  cur_dp = 4'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_val[i] = 4'h0;
    m_valid = 4'h0;
    m_dp    = 4'h0;
    m_seen  = 4'h0;
  endtask

  task automatic model_accept(input logic [3:0] a, input logic [7:0] s);
    int   zeros;
    int   n;
    bit   hex;
    logic [3:0] v;
    ev_t  e;
    zeros = 0;
    n = 0;
    for (int i = 0; i < 4; i++) if (!a[i]) begin zeros++; n = i; end
    e = '{fd: 1'b0, ce: 1'b0, se: 1'b0, dg: 16'h0, vl: 4'h0, dp: 4'h0};
    if (zeros == 0) return;
    if (zeros > 1) begin
      e.se = 1'b1;
      exp_q.push_back(e);
      return;
    end
    hex = 1'b0;
    v = 4'h0;
    for (int k = 0; k < 16; k++) if (tbl[k] == s[6:0]) begin hex = 1'b1; v = 4'(k); end
    m_val[n]   = v;
    m_valid[n] = hex;
    m_dp[n]    = DP_ON && !s[7];
    m_seen[n]  = 1'b1;
    if (!hex && s[6:0] != 7'h7F) e.ce = 1'b1;
    if (m_seen == 4'hF) begin
      e.fd = 1'b1;
      e.dg = {m_val[3], m_val[2], m_val[1], m_val[0]};
      e.vl = m_valid;
      e.dp = m_dp;
      m_seen = 4'h0;
    end
    if (e.fd || e.ce) exp_q.push_back(e);
  endtask

  // Drive a pattern for n clock edges; inputs change on the falling edge
  task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
    anodes   = a;
    segments = s;
    if (n >= STABLE) model_accept(a, s);
    repeat (n) @(negedge clk);
  endtask

  task automatic scan4(input logic [7:0] s0, s1, s2, s3);
    hold(4'b1110, s0, 10);
    hold(4'b1101, s1, 10);
    hold(4'b1011, s2, 10);
    hold(4'b0111, s3, 10);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  initial begin
    ev_t e;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        chk("reset_outputs", {digits, valid, dps, frame_done, code_err, scan_err}, 32'h0);
        cur_dg = 16'h0;
        cur_vl = 4'h0;
        cur_dp = 4'h0;
      end else begin
        if (frame_done || code_err || scan_err) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_pulse", {frame_done, code_err, scan_err}, 3'b000);
          end else begin
            e = exp_q.pop_front();
            $display("event fd=%0b ce=%0b se=%0b digits=%h valid=%h dps=%h",
                     frame_done, code_err, scan_err, digits, valid, dps);
            chk("pulses", {frame_done, code_err, scan_err}, {e.fd, e.ce, e.se});
            if (e.fd) begin
              cur_dg = e.dg;
              cur_vl = e.vl;
              cur_dp = e.dp;
            end
          end
        end
        chk("latched_outputs", {digits, valid, dps}, {cur_dg, cur_vl, cur_dp});
      end
    end
  end

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [11:0] prev_key;
    logic [11:0] key;
    logic [3:0]  a;
    logic [7:0]  s;
    int          r;

    model_reset();
    rst      = 1'b1;
    anodes   = 4'hF;
    segments = 8'hFF;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    hold(4'hF, 8'hFF, 3);

    // Basic scan: 3,1,2,0 on digits 0..3
    scan4(8'hB0, 8'hF9, 8'hA4, 8'hC0);
    hold(4'hF, 8'hFF, 5);
    chk("scan_digits", digits, 16'h0213);
    chk("scan_valid", valid, 4'hF);

    // Too short a hold must not be accepted
    hold(4'b1101, 8'hC0, STABLE - 1);
    hold(4'hF, 8'hFF, 5);

    // Two anodes low: scan error, nothing stored
    hold(4'b1100, 8'hC0, 10);
    hold(4'hF, 8'hFF, 5);
    chk("scan_err_digits", digits, 16'h0213);

    // Blank then illegal code on digit 2
    scan4(8'hC0, 8'hF9, 8'hFF, 8'hB0);
    hold(4'hF, 8'hFF, 5);
    chk("blank_valid", valid, 4'b1011);
    scan4(8'hC0, 8'hF9, 8'hD5, 8'hB0);
    hold(4'hF, 8'hFF, 5);
    chk("illegal_valid", valid, 4'b1011);
    chk("illegal_digits", digits, 16'h3010);

    // Reset mid-frame, then scan in an order that exposes stale seen bits
    hold(4'b1110, 8'hB0, 10);
    hold(4'b1101, 8'hF9, 10);
    hold(4'hF, 8'hFF, 5);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    hold(4'hF, 8'hFF, 2);
    hold(4'b1011, 8'hA4, 10);
    hold(4'b0111, 8'hB0, 10);
    hold(4'b1110, 8'h40, 10);
    hold(4'b1101, 8'hF9, 10);
    hold(4'hF, 8'hFF, 5);
    chk("post_reset_digits", digits, 16'h3210);
    chk("post_reset_dps", dps, DP_ON ? 4'b0001 : 4'b0000);

    // Randomized holds
    prev_key = {4'hF, 8'hFF & KEY_MASK};
    for (int t = 0; t < 300; t++) begin
      do begin
        r = $urandom_range(0, 99);
        if (r < 70)      a = ~(4'b0001 << $urandom_range(0, 3));
        else if (r < 82) a = 4'hF;
        else             a = 4'($urandom_range(0, 15));
        r = $urandom_range(0, 99);
        if (r < 60)      s = {1'($urandom_range(0, 1)), tbl[$urandom_range(0, 15)]};
        else if (r < 75) s = {1'($urandom_range(0, 1)), 7'h7F};
        else             s = 8'($urandom_range(0, 255));
        key = {a, s & KEY_MASK};
      end while (key == prev_key);
      prev_key = key;
      hold(a, s, $urandom_range(1, 2 * STABLE + 1));
    end
    hold(4'hF, 8'hFF, 2 * STABLE + 10);

    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
